cdc_handshake_rx: RTL and testbench

//   Receive-side controller for a 4-phase req/ack crossing into the clk domain.

---
 rtl/cdc_handshake_rx.sv | 85 ++++++++
 tb/tb_cdc_handshake_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_rx.sv
// Receive side of a 4-phase req/ack crossing: synchronise req, capture the held word,
// acknowledge the source, and present each word once on a 1-entry valid/ready buffer.
module cdc_handshake_rx #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              async_req,
  input  logic [DATA_W-1:0] async_data,
  output logic              async_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              busy
);

  typedef enum logic {IDLE, ACK_HI} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   capture;
  logic                   deliver;
  logic                   ack_nxt;
  logic                   valid_nxt;

  // Plain flop chain only; async_data is never synchronised, it is held stable by the source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], async_req};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A full buffer that is not draining this edge withholds the ack (backpressure to source).
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ack_nxt   = async_ack;
    case (state)
      IDLE: begin
        if (req_s && (!out_valid || out_ready)) begin
          capture   = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign deliver   = out_valid & out_ready;
  assign valid_nxt = capture | (out_valid & ~out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      async_ack <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      xfer_cnt  <= '0;
    end else begin
      async_ack <= ack_nxt;
      out_valid <= valid_nxt;
      if (capture) out_data <= async_data;
      if (deliver) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  assign busy = (state != IDLE) | out_valid;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Scoreboard bench for cdc_handshake_rx: the source pushes each word it offers,
// a monitor pops and compares on every out_valid & out_ready beat.
module tb_cdc_handshake_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        async_req = 1'b0;
  logic [31:0] async_data = '0;
  logic        async_ack;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [3:0]  xfer_cnt;
  logic        busy;

  int          n_vec = 0;
  int          n_miss = 0;
  int          exp_cnt = 0;
  int          ack_edges = 0;
  bit          rand_mode = 1'b0;
  bit          ready_cmd = 1'b0;
  logic [31:0] q[$];

  cdc_handshake_rx #(.DATA_W(32), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .async_req(async_req), .async_data(async_data),
    .async_ack(async_ack), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt), .busy(busy)
  );

  always #15 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) exp_cnt = 0;
      else if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_word", out_data, 32'hxxxx_xxxx);
        else begin
          e = q.pop_front();
          chk("out_data", out_data, e);
        end
        chk("xfer_cnt_at_beat", 32'(xfer_cnt), 32'(exp_cnt));
        exp_cnt = (exp_cnt + 1) % 16;
      end
    end
  endtask

  task automatic ack_watch();
    forever begin
      @(async_ack);
      ack_edges++;
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_cmd;
    end
  endtask

  // Full 4-phase transfer paced by the source's own step, asynchronous to clk.
  task automatic xfer(input logic [31:0] d, input int step);
    int t;
    int e0;
    async_data = d;
    #step;
    q.push_back(d);
    e0 = ack_edges;
    async_req = 1'b1;
    t = 0;
    while (async_ack !== 1'b1 && t < 500) begin #step; t++; end
    chk("xfer_ack_rise", 32'(async_ack), 32'd1);
    #step;
    async_req = 1'b0;
    t = 0;
    while (async_ack !== 1'b0 && t < 500) begin #step; t++; end
    chk("xfer_ack_fall", 32'(async_ack), 32'd0);
    chk("xfer_ack_toggles", 32'(ack_edges - e0), 32'd2);
    #step;
  endtask

  initial begin
    int  t;
    int  cnt0;
    bit  held;

    fork
      monitor();
      ack_watch();
      ready_drv();
    join_none

    // reset state
    ready_cmd = 1'b1;
    cyc(3);
    chk("rst_ack", 32'(async_ack), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cyc(2);

    // single transfer, cycle-exact latency
    async_data = 32'hA5A5_0001;
    q.push_back(32'hA5A5_0001);
    async_req = 1'b1;
    cyc(2);
    chk("t1_ack_e2", 32'(async_ack), 32'd0);
    cyc(1);
    chk("t1_ack_e3", 32'(async_ack), 32'd1);
    chk("t1_valid_e3", 32'(out_valid), 32'd1);
    chk("t1_data_e3", out_data, 32'hA5A5_0001);
    chk("t1_busy_e3", 32'(busy), 32'd1);
    cyc(1);
    chk("t1_valid_e4", 32'(out_valid), 32'd0);
    chk("t1_cnt_e4", 32'(xfer_cnt), 32'd1);
    async_req = 1'b0;
    cyc(2);
    chk("t1_ack_fall_e2", 32'(async_ack), 32'd1);
    cyc(1);
    chk("t1_ack_fall_e3", 32'(async_ack), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // backpressure: second word waits for the first to drain
    ready_cmd = 1'b0;
    cyc(3);
    xfer(32'h1111_0001, 10);
    async_data = 32'h2222_0002;
    q.push_back(32'h2222_0002);
    async_req = 1'b1;
    cyc(6);
    chk("t2_ack_held", 32'(async_ack), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_first_word", out_data, 32'h1111_0001);
    ready_cmd = 1'b1;
    held = 1'b1;
    t = 0;
    while (async_ack !== 1'b1 && t < 10) begin
      cyc(1);
      if (out_valid !== 1'b1) held = 1'b0;
      t++;
    end
    chk("t2_ack_rise", 32'(async_ack), 32'd1);
    chk("t2_valid_never_dropped", 32'(held), 32'd1);
    async_req = 1'b0;
    t = 0;
    while (async_ack !== 1'b0 && t < 10) begin cyc(1); t++; end
    chk("t2_ack_fall", 32'(async_ack), 32'd0);
    cyc(3);

    // burst of 8 with random out_ready
    cnt0 = exp_cnt;
    rand_mode = 1'b1;
    for (int i = 0; i < 8; i++) xfer(32'(i), 10);
    rand_mode = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 50) begin cyc(1); t++; end
    cyc(2);
    chk("t3_drained", 32'(q.size()), 32'd0);
    chk("t3_cnt", 32'(xfer_cnt), 32'((cnt0 + 8) % 16));

    // counter wrap with a 4-bit counter
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    for (int i = 1; i <= 17; i++) begin
      xfer(32'hC000_0000 + 32'(i), 10);
      cyc(2);
      chk("t4_wrap_cnt", 32'(xfer_cnt), 32'(i % 16));
    end

    // reset while in ACK_HI with req still held
    ready_cmd = 1'b0;
    cyc(2);
    async_data = 32'h5EED_0005;
    q.push_back(32'h5EED_0005);
    async_req = 1'b1;
    t = 0;
    while (async_ack !== 1'b1 && t < 10) begin cyc(1); t++; end
    chk("t5_ack_before", 32'(async_ack), 32'd1);
    reset = 1'b1;
    cyc(2);
    chk("t5_rst_ack", 32'(async_ack), 32'd0);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", out_data, 32'd0);
    chk("t5_rst_cnt", 32'(xfer_cnt), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    t = 0;
    while (async_ack !== 1'b1 && t < 10) begin cyc(1); t++; end
    chk("t5_ack_again", 32'(async_ack), 32'd1);
    chk("t5_valid_again", 32'(out_valid), 32'd1);
    chk("t5_data_again", out_data, 32'h5EED_0005);
    ready_cmd = 1'b1;
    async_req = 1'b0;
    t = 0;
    while (async_ack !== 1'b0 && t < 10) begin cyc(1); t++; end
    cyc(3);
    chk("t5_ack_fall", 32'(async_ack), 32'd0);
    chk("t5_drained", 32'(out_valid), 32'd0);

    // clock ratio sweep: source 3x faster, then 7x slower than clk
    for (int i = 0; i < 4; i++) xfer(32'hF000_0000 + 32'(i), 10);
    for (int i = 0; i < 4; i++) xfer(32'h5000_0000 + 32'(i), 210);

    t = 0;
    while (q.size() != 0 && t < 50) begin cyc(1); t++; end
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
